// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access in flight at a time: grant -> issue -> respond, or grant -> error response.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_wr,
  input  logic [ADDR_W-1:0] ext_adr,
  input  logic [DATA_W-1:0] ext_wd,
  output logic              ext_ack,
  output logic              ext_err,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_wr,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [CNT_W-1:0]  cpu_gnt_cnt,
  output logic [CNT_W-1:0]  ext_gnt_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISS,
    CPU_RSP,
    EXT_ISS,
    EXT_RSP,
    ERR_RSP
  } state_t;

  state_t state, state_nxt;

  // last_ext also identifies the owner of ERR_RSP: it always holds the most recent grant.
  logic              last_ext;
  logic              sel_ext;
  logic              grant;
  logic              gnt_ok;
  logic              gnt_wr;
  logic [ADDR_W-1:0] gnt_adr;
  logic [DATA_W-1:0] gnt_wd;

  always_comb begin
    sel_ext = ext_req && (!cpu_req || !last_ext);
    gnt_wr  = sel_ext ? ext_wr  : cpu_wr;
    gnt_adr = sel_ext ? ext_adr : cpu_adr;
    gnt_wd  = sel_ext ? ext_wd  : cpu_wd;
    gnt_ok  = (gnt_adr[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req || ext_req) begin
          grant = 1'b1;
          if (!gnt_ok)      state_nxt = ERR_RSP;
          else if (sel_ext) state_nxt = EXT_ISS;
          else              state_nxt = CPU_ISS;
        end
      end
      CPU_ISS: state_nxt = CPU_RSP;
      EXT_ISS: state_nxt = EXT_RSP;
      CPU_RSP, EXT_RSP, ERR_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      last_ext    <= 1'b1;
      mem_adr     <= '0;
      mem_wd      <= '0;
      mem_wr      <= 1'b0;
      mem_oe      <= 1'b0;
      cpu_rdata   <= '0;
      ext_rdata   <= '0;
      cpu_gnt_cnt <= '0;
      ext_gnt_cnt <= '0;
    end else begin
      mem_wr <= 1'b0;
      mem_oe <= 1'b0;
      if (grant) begin
        last_ext <= sel_ext;
        if (gnt_ok) begin
          mem_adr <= gnt_adr;
          mem_wd  <= gnt_wd;
          mem_wr  <= gnt_wr;
          mem_oe  <= !gnt_wr;
        end
      end
      if (state == CPU_ISS && mem_oe) cpu_rdata <= mem_rd;
      if (state == EXT_ISS && mem_oe) ext_rdata <= mem_rd;
      if (state == CPU_RSP && cpu_gnt_cnt != '1) cpu_gnt_cnt <= cpu_gnt_cnt + 1'b1;
      if (state == EXT_RSP && ext_gnt_cnt != '1) ext_gnt_cnt <= ext_gnt_cnt + 1'b1;
    end
  end

  always_comb begin
    cpu_err   = (state == ERR_RSP) && !last_ext;
    ext_err   = (state == ERR_RSP) &&  last_ext;
    cpu_ack   = (state == CPU_RSP) || cpu_err;
    ext_ack   = (state == EXT_RSP) || ext_err;
    cpu_stall = cpu_req && !cpu_ack;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed transaction table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic        clk;
  logic        RESET_N;
  logic        r_req [2];
  logic        r_wr  [2];
  logic [31:0] r_adr [2];
  logic [31:0] r_wd  [2];

  logic        cpu_ack, cpu_err, cpu_stall, ext_ack, ext_err, mem_wr, mem_oe;
  logic [31:0] cpu_rdata, ext_rdata, mem_adr, mem_wd, mem_rd;
  logic [CNT_W-1:0] cpu_gnt_cnt, ext_gnt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .cpu_req(r_req[0]), .cpu_wr(r_wr[0]), .cpu_adr(r_adr[0]), .cpu_wd(r_wd[0]),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(r_req[1]), .ext_wr(r_wr[1]), .ext_adr(r_adr[1]), .ext_wd(r_wd[1]),
    .ext_ack(ext_ack), .ext_err(ext_err), .ext_rdata(ext_rdata),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_oe(mem_oe), .mem_rd(mem_rd),
    .cpu_gnt_cnt(cpu_gnt_cnt), .ext_gnt_cnt(ext_gnt_cnt)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h10) ? 32'hDEADBEEF : {~lo, lo};
  endfunction

  assign mem_rd = mem_fn(mem_adr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by its age since grant.
  bit          m_active;
  int          m_port, m_age, m_len;
  bit          m_err, m_wr, m_last_ext;
  logic [31:0] m_adr, m_wd;
  logic [31:0] m_rdata [2];
  int unsigned m_cnt   [2];

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      m_active = 0; m_last_ext = 1; m_age = 0; m_len = 0;
      m_rdata[0] = '0; m_rdata[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_active) begin
      if (m_age == m_len - 1) begin
        if (!m_err && m_cnt[m_port] < CMAX) m_cnt[m_port]++;
        m_active = 0;
      end else begin
        if (m_age == 0 && !m_wr) m_rdata[m_port] = mem_fn(m_adr);
        m_age++;
      end
    end else if (r_req[0] || r_req[1]) begin
      if (r_req[0] && r_req[1]) m_port = m_last_ext ? 0 : 1;
      else                      m_port = r_req[1] ? 1 : 0;
      m_last_ext = (m_port == 1);
      m_wr  = r_wr[m_port];
      m_adr = r_adr[m_port];
      m_wd  = r_wd[m_port];
      m_err = (m_adr % 4) != 0;
      m_len = m_err ? 1 : 2;
      m_age = 0;
      m_active = 1;
    end
  end

  function automatic bit m_ack(input int p);
    return m_active && m_port == p && m_age == m_len - 1;
  endfunction

  task automatic check_model();
    bit iss;
    iss = m_active && !m_err && m_age == 0;
    chk("rnd_cpu_ack", cpu_ack, m_ack(0));
    chk("rnd_ext_ack", ext_ack, m_ack(1));
    chk("rnd_cpu_err", cpu_err, m_ack(0) && m_err);
    chk("rnd_ext_err", ext_err, m_ack(1) && m_err);
    chk("rnd_mem_wr", mem_wr, iss && m_wr);
    chk("rnd_mem_oe", mem_oe, iss && !m_wr);
    if (iss) begin
      chk("rnd_mem_adr", mem_adr, m_adr);
      chk("rnd_mem_wd", mem_wd, m_wd);
    end
    chk("rnd_cpu_rdata", cpu_rdata, m_rdata[0]);
    chk("rnd_ext_rdata", ext_rdata, m_rdata[1]);
    chk("rnd_cpu_cnt", cpu_gnt_cnt, m_cnt[0]);
    chk("rnd_ext_cnt", ext_gnt_cnt, m_cnt[1]);
    chk("rnd_cpu_stall", cpu_stall, r_req[0] && !m_ack(0));
  endtask

  task automatic new_req(input int p);
    r_req[p] = 1'b1;
    r_wr[p]  = 1'($urandom_range(0, 1));
    r_adr[p] = $urandom;
    if ($urandom_range(0, 4) != 0) r_adr[p][1:0] = 2'b00;
    r_wd[p]  = $urandom;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_wr[p] = 1'b0; r_adr[p] = '0; r_wd[p] = '0;
    end
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
  endtask

  typedef struct {
    bit          ext;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] wd;
    bit          exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_cnt;
  } txn_t;

  txn_t tbl [8];

  task automatic run_txn(input txn_t t);
    int  p, n;
    bit  got;
    p = t.ext ? 1 : 0;
    r_req[p] = 1'b1; r_wr[p] = t.wr; r_adr[p] = t.adr; r_wd[p] = t.wd;
    got = 0; n = 0;
    while (!got && n < 6) begin
      @(posedge clk); @(negedge clk); n++;
      if (t.exp_err) chk("tbl_no_mem_access", mem_wr || mem_oe, 1'b0);
      else if (n == 1) begin
        chk("tbl_mem_adr", mem_adr, t.adr);
        chk("tbl_mem_wd", mem_wd, t.wd);
        chk("tbl_mem_wr", mem_wr, t.wr);
        chk("tbl_mem_oe", mem_oe, !t.wr);
        r_adr[p] = $urandom; r_wd[p] = $urandom;
      end
      chk("tbl_other_ack", t.ext ? cpu_ack : ext_ack, 1'b0);
      if (!t.ext) chk("tbl_stall", cpu_stall, !cpu_ack);
      if (t.ext ? ext_ack : cpu_ack) begin
        got = 1;
        chk("tbl_latency", n, t.exp_lat);
        chk("tbl_err", t.ext ? ext_err : cpu_err, t.exp_err);
        chk("tbl_rdata", t.ext ? ext_rdata : cpu_rdata, t.exp_rdata);
        if (!t.exp_err) chk("tbl_mem_adr_hold", mem_adr, t.adr);
        r_req[p] = 1'b0;
      end
    end
    if (!got) chk("tbl_ack_timeout", 0, 1);
    r_req[p] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("tbl_cnt", t.ext ? ext_gnt_cnt : cpu_gnt_cnt, t.exp_cnt);
  endtask

  initial begin
    tbl[0] = '{0, 0, 32'h10,       32'h0,        0, 2, 32'hDEADBEEF, 1};
    tbl[1] = '{1, 1, 32'h6,        32'h1111,     1, 1, 32'h0,        0};
    tbl[2] = '{1, 0, 32'h24,       32'h0,        0, 2, 32'hFFDB0024, 1};
    tbl[3] = '{0, 1, 32'h40,       32'hA5A5A5A5, 0, 2, 32'hDEADBEEF, 2};
    tbl[4] = '{0, 0, 32'h3,        32'h0,        1, 1, 32'hDEADBEEF, 2};
    tbl[5] = '{1, 1, 32'hFFFFFFFC, 32'h12345678, 0, 2, 32'hFFDB0024, 2};
    tbl[6] = '{0, 0, 32'h100,      32'h0,        0, 2, 32'hFEFF0100, 3};
    tbl[7] = '{0, 0, 32'h0,        32'h0,        0, 2, 32'hFFFF0000, 3};

    do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_ext_ack", ext_ack, 1'b0);
    chk("rst_mem_ctl", {mem_wr, mem_oe}, 2'b00);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cnts", {cpu_gnt_cnt, ext_gnt_cnt}, 0);
    @(negedge clk);
    RESET_N = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Both ports requesting continuously: CPU wins the first tie, then alternation.
    do_reset();
    r_req[0] = 1; r_wr[0] = 0; r_adr[0] = 32'h8;
    r_req[1] = 1; r_wr[1] = 0; r_adr[1] = 32'hC;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rr_cpu_ack", cpu_ack, (i == 1 || i == 7));
      chk("rr_ext_ack", ext_ack, (i == 4 || i == 10));
    end
    chk("rr_cpu_rdata", cpu_rdata, 32'hFFF70008);
    chk("rr_ext_rdata", ext_rdata, 32'hFFF3000C);
    chk("rr_cnts", {cpu_gnt_cnt, ext_gnt_cnt}, {2'd2, 2'd2});
    r_req[0] = 0; r_req[1] = 0;

    // Reset landing in the issue cycle of a CPU write.
    do_reset();
    r_req[0] = 1; r_wr[0] = 1; r_adr[0] = 32'h20; r_wd[0] = 32'h55;
    @(posedge clk); @(negedge clk);
    chk("rstmid_mem_wr_before", mem_wr, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rstmid_mem_wr_drop", mem_wr, 1'b0);
    chk("rstmid_no_ack", cpu_ack, 1'b0);
    r_req[1] = 1; r_wr[1] = 0; r_adr[1] = 32'h30;
    @(negedge clk);
    chk("rstmid_no_ack_held", cpu_ack, 1'b0);
    RESET_N = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        chk("rstmid_regrant_wr", mem_wr, 1'b1);
        chk("rstmid_regrant_adr", mem_adr, 32'h20);
      end else begin
        chk("rstmid_cpu_ack", cpu_ack, 1'b1);
        chk("rstmid_ext_ack", ext_ack, 1'b0);
      end
    end
    r_req[0] = 0; r_req[1] = 0;

    // CPU alone holding req: stall drops only in ack cycles; address changes after grant are ignored.
    do_reset();
    r_req[0] = 1; r_wr[0] = 0; r_adr[0] = 32'h44;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_stall", cpu_stall, !(i % 3 == 1));
      if (i % 3 != 2) chk("hold_mem_adr", mem_adr, 32'h44);
      if (i % 3 == 0) r_adr[0] = $urandom;
      if (i % 3 == 1) r_adr[0] = 32'h44;
    end
    r_req[0] = 0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); @(negedge clk);
      check_model();
      for (int p = 0; p < 2; p++) begin
        if (m_ack(p)) begin
          if ($urandom_range(0, 1) == 1) new_req(p);
          else r_req[p] = 1'b0;
        end else if (!r_req[p]) begin
          if ($urandom_range(0, 2) == 0) new_req(p);
        end else if (m_active && m_port == p) begin
          r_adr[p] = $urandom;
          r_wd[p]  = $urandom;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
